// File: rtl/encoder.sv
// Registered 8b/10b line encoder: one byte plus K flag per clock into a 10-bit
// code group (abcdei fghj), with running disparity carried between symbols.
module encoder (
    input  logic       INTERCLK,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       TXDATAK,
    input  logic       TXCOMP,
    output logic [9:0] oData
);

    localparam int unsigned X_W    = 5;
    localparam int unsigned Y_W    = 3;
    localparam int unsigned SB6_W  = 6;
    localparam int unsigned SB4_W  = 4;
    localparam int unsigned CODE_W = SB6_W + SB4_W;

    // 5b/6b data table, returns {rd_neg_form, rd_pos_form}
    function automatic logic [2*SB6_W-1:0] lut_5b6b(input logic [X_W-1:0] x);
        case (x)
            5'd0:    return {6'b100111, 6'b011000};
            5'd1:    return {6'b011101, 6'b100010};
            5'd2:    return {6'b101101, 6'b010010};
            5'd3:    return {6'b110001, 6'b110001};
            5'd4:    return {6'b110101, 6'b001010};
            5'd5:    return {6'b101001, 6'b101001};
            5'd6:    return {6'b011001, 6'b011001};
            5'd7:    return {6'b111000, 6'b000111};
            5'd8:    return {6'b111001, 6'b000110};
            5'd9:    return {6'b100101, 6'b100101};
            5'd10:   return {6'b010101, 6'b010101};
            5'd11:   return {6'b110100, 6'b110100};
            5'd12:   return {6'b001101, 6'b001101};
            5'd13:   return {6'b101100, 6'b101100};
            5'd14:   return {6'b011100, 6'b011100};
            5'd15:   return {6'b010111, 6'b101000};
            5'd16:   return {6'b011011, 6'b100100};
            5'd17:   return {6'b100011, 6'b100011};
            5'd18:   return {6'b010011, 6'b010011};
            5'd19:   return {6'b110010, 6'b110010};
            5'd20:   return {6'b001011, 6'b001011};
            5'd21:   return {6'b101010, 6'b101010};
            5'd22:   return {6'b011010, 6'b011010};
            5'd23:   return {6'b111010, 6'b000101};
            5'd24:   return {6'b110011, 6'b001100};
            5'd25:   return {6'b100110, 6'b100110};
            5'd26:   return {6'b010110, 6'b010110};
            5'd27:   return {6'b110110, 6'b001001};
            5'd28:   return {6'b001110, 6'b001110};
            5'd29:   return {6'b101110, 6'b010001};
            5'd30:   return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    // 3b/4b data table (primary form for y=7), returns {rd_neg_form, rd_pos_form}
    function automatic logic [2*SB4_W-1:0] lut_3b4b(input logic [Y_W-1:0] y);
        case (y)
            3'd0:    return {4'b1011, 4'b0100};
            3'd1:    return {4'b1001, 4'b1001};
            3'd2:    return {4'b0101, 4'b0101};
            3'd3:    return {4'b1100, 4'b0011};
            3'd4:    return {4'b1101, 4'b0010};
            3'd5:    return {4'b1010, 4'b1010};
            3'd6:    return {4'b0110, 4'b0110};
            default: return {4'b1110, 4'b0001};
        endcase
    endfunction

    // Disparity after a 6b sub-block: more ones -> positive, fewer -> negative
    function automatic logic next_rd6(input logic [SB6_W-1:0] sb, input logic rd);
        logic [2:0] ones;
        ones = '0;
        for (int i = 0; i < int'(SB6_W); i++) ones = ones + 3'(sb[i]);
        if (ones > 3'd3) return 1'b1;
        if (ones < 3'd3) return 1'b0;
        return rd;
    endfunction

    function automatic logic next_rd4(input logic [SB4_W-1:0] sb, input logic rd);
        logic [2:0] ones;
        ones = '0;
        for (int i = 0; i < int'(SB4_W); i++) ones = ones + 3'(sb[i]);
        if (ones > 3'd2) return 1'b1;
        if (ones < 3'd2) return 1'b0;
        return rd;
    endfunction

    logic [CODE_W-1:0]  code_q, code_d;
    logic               rd_q, rd_d;

    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               rd_in;
    logic               rd_mid;
    logic               k_is28;
    logic               k_is_x7;
    logic               k_valid;
    logic               a7_sel;
    logic [2*SB6_W-1:0] sb6_pair;
    logic [2*SB4_W-1:0] sb4_pair;
    logic [SB6_W-1:0]   sb6;
    logic [SB4_W-1:0]   sb4_data;
    logic [SB4_W-1:0]   sb4;

    // Encode current input against stored RD (or forced RD- in compliance mode)
    always_comb begin
        x        = iData[4:0];
        y        = iData[7:5];
        rd_in    = rd_q & ~TXCOMP;
        k_is28   = TXDATAK && (x == 5'd28);
        k_is_x7  = TXDATAK && (y == 3'd7) &&
                   ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));
        k_valid  = k_is28 || k_is_x7;
        sb6_pair = lut_5b6b(x);
        sb4_pair = lut_3b4b(y);

        if (k_is28) sb6 = rd_in ? 6'b110000 : 6'b001111;
        else        sb6 = rd_in ? sb6_pair[SB6_W-1:0] : sb6_pair[2*SB6_W-1:SB6_W];
        rd_mid = next_rd6(sb6, rd_in);

        // Alternate y=7 form avoids a run of five across the sub-block boundary
        a7_sel   = (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                   ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        sb4_data = rd_mid ? sb4_pair[SB4_W-1:0] : sb4_pair[2*SB4_W-1:SB4_W];

        if ((y == 3'd7) && (k_valid || a7_sel)) begin
            sb4 = rd_mid ? 4'b1000 : 4'b0111;
        end else if (k_is28 && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) begin
            sb4 = rd_mid ? sb4_data : ~sb4_data;
        end else begin
            sb4 = sb4_data;
        end

        rd_d   = next_rd4(sb4, rd_mid);
        code_d = {sb6, sb4};
    end

    always_ff @(posedge INTERCLK) begin
        if (!Reset) begin
            code_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            code_q <= code_d;
            rd_q   <= rd_d;
        end
    end

    assign oData = code_q;

endmodule

// File: tb/tb_encoder.sv
// Directed and sweep bench for the 8b/10b encoder: hand-computed code groups
// plus stream properties (disparity, running disparity, run length, uniqueness).
module tb_encoder;

    logic       INTERCLK;
    logic       Reset;
    logic [7:0] iData;
    logic       TXDATAK;
    logic       TXCOMP;
    logic [9:0] oData;

    int pass_cnt;
    int total_cnt;

    typedef struct packed {
        logic       r;
        logic [7:0] d;
        logic       k;
        logic       c;
        logic [9:0] e;
    } vec_t;

    encoder dut (
        .INTERCLK (INTERCLK),
        .Reset    (Reset),
        .iData    (iData),
        .TXDATAK  (TXDATAK),
        .TXCOMP   (TXCOMP),
        .oData    (oData)
    );

    initial INTERCLK = 1'b0;
    always #5 INTERCLK = ~INTERCLK;

    function automatic vec_t mk(input logic r, input logic [7:0] d, input logic k,
                                input logic c, input logic [9:0] e);
        vec_t v;
        v.r = r; v.d = d; v.k = k; v.c = c; v.e = e;
        return v;
    endfunction

    task automatic send(input logic [7:0] d, input logic k, input logic c);
        iData = d; TXDATAK = k; TXCOMP = c;
        @(posedge INTERCLK);
        #1;
    endtask

    task automatic test_reset();
        vec_t v [$];
        v.push_back(mk(1'b0, 8'hBC, 1'b1, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b0, 8'hBC, 1'b1, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b0, 10'b0011111010));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b0, 10'b1100000101));
        foreach (v[i]) begin
            Reset = v[i].r;
            send(v[i].d, v[i].k, v[i].c);
            total_cnt++;
            if (oData !== v[i].e) $display("FAIL reset[%0d]: oData=%b expected=%b", i, oData, v[i].e);
            else pass_cnt++;
        end
        Reset = 1'b1;
    endtask

    task automatic test_data();
        vec_t v [$];
        v.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 10'b1001110100));
        v.push_back(mk(1'b1, 8'hB5, 1'b0, 1'b0, 10'b1010101010));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b0, 10'b0011111010));
        v.push_back(mk(1'b1, 8'hB5, 1'b0, 1'b0, 10'b1010101010));
        v.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 10'b0110001011));
        v.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 10'b0110001011));
        foreach (v[i]) begin
            Reset = v[i].r;
            send(v[i].d, v[i].k, v[i].c);
            total_cnt++;
            if (oData !== v[i].e) $display("FAIL data[%0d]: oData=%b expected=%b", i, oData, v[i].e);
            else pass_cnt++;
        end
        Reset = 1'b1;
    endtask

    task automatic test_a7_p7();
        vec_t v [$];
        v.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b1, 8'hF1, 1'b0, 1'b0, 10'b1000110111));
        v.push_back(mk(1'b1, 8'hEB, 1'b0, 1'b0, 10'b1101001000));
        v.push_back(mk(1'b1, 8'hE3, 1'b0, 1'b0, 10'b1100011110));
        v.push_back(mk(1'b1, 8'hEE, 1'b0, 1'b0, 10'b0111001000));
        v.push_back(mk(1'b1, 8'hEB, 1'b0, 1'b0, 10'b1101001110));
        v.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 10'b0101001110));
        v.push_back(mk(1'b1, 8'hF1, 1'b0, 1'b0, 10'b1000110001));
        foreach (v[i]) begin
            Reset = v[i].r;
            send(v[i].d, v[i].k, v[i].c);
            total_cnt++;
            if (oData !== v[i].e) $display("FAIL a7_p7[%0d]: oData=%b expected=%b", i, oData, v[i].e);
            else pass_cnt++;
        end
        Reset = 1'b1;
    endtask

    task automatic test_k_codes();
        vec_t v [$];
        v.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b1, 8'hFC, 1'b1, 1'b1, 10'b0011111000));
        v.push_back(mk(1'b1, 8'hF7, 1'b1, 1'b1, 10'b1110101000));
        v.push_back(mk(1'b1, 8'h3C, 1'b1, 1'b1, 10'b0011111001));
        v.push_back(mk(1'b1, 8'hBC, 1'b0, 1'b1, 10'b0011101010));
        v.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 10'b1001110100));
        v.push_back(mk(1'b1, 8'h07, 1'b0, 1'b1, 10'b1110001011));
        v.push_back(mk(1'b1, 8'hFB, 1'b1, 1'b1, 10'b1101101000));
        v.push_back(mk(1'b1, 8'hFD, 1'b1, 1'b1, 10'b1011101000));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b1, 10'b0011111010));
        v.push_back(mk(1'b1, 8'hFE, 1'b1, 1'b0, 10'b1000010111));
        v.push_back(mk(1'b1, 8'h5C, 1'b1, 1'b0, 10'b1100001010));
        v.push_back(mk(1'b1, 8'hDC, 1'b1, 1'b0, 10'b0011110110));
        v.push_back(mk(1'b1, 8'h1C, 1'b1, 1'b0, 10'b1100001011));
        v.push_back(mk(1'b1, 8'hF1, 1'b1, 1'b0, 10'b1000110001));
        foreach (v[i]) begin
            Reset = v[i].r;
            send(v[i].d, v[i].k, v[i].c);
            total_cnt++;
            if (oData !== v[i].e) $display("FAIL k_codes[%0d]: oData=%b expected=%b", i, oData, v[i].e);
            else pass_cnt++;
        end
        Reset = 1'b1;
    endtask

    task automatic test_compliance();
        vec_t v [$];
        v.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b0, 10'b0011111010));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b1, 10'b0011111010));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b0, 10'b1100000101));
        foreach (v[i]) begin
            Reset = v[i].r;
            send(v[i].d, v[i].k, v[i].c);
            total_cnt++;
            if (oData !== v[i].e) $display("FAIL compliance[%0d]: oData=%b expected=%b", i, oData, v[i].e);
            else pass_cnt++;
        end
        Reset = 1'b1;
    endtask

    task automatic test_reset_midstream();
        vec_t v [$];
        v.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b0, 10'b0011111010));
        v.push_back(mk(1'b0, 8'hBC, 1'b1, 1'b0, 10'b0000000000));
        v.push_back(mk(1'b1, 8'hBC, 1'b1, 1'b0, 10'b0011111010));
        foreach (v[i]) begin
            Reset = v[i].r;
            send(v[i].d, v[i].k, v[i].c);
            total_cnt++;
            if (oData !== v[i].e) $display("FAIL reset_mid[%0d]: oData=%b expected=%b", i, oData, v[i].e);
            else pass_cnt++;
        end
        Reset = 1'b1;
    endtask

    // mode 0: natural stream; mode 1: each symbol at RD-; mode 2: each symbol at RD+
    task automatic test_sweep();
        logic [7:0]  klist [12];
        logic [9:0]  seen [268];
        logic [19:0] bits;
        logic [7:0]  d;
        logic        k;
        int nbits, sum, run, last, ones, max_run, bad_sum, bad_ones, dups;
        klist = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                  8'hF7, 8'hFB, 8'hFD, 8'hFE};
        for (int mode = 0; mode < 3; mode++) begin
            Reset = 1'b0;
            send(8'h00, 1'b0, 1'b0);
            Reset = 1'b1;
            sum = -1; run = 0; last = -1;
            for (int i = 0; i < 268; i++) begin
                if (i < 256) begin d = 8'(i); k = 1'b0; end
                else begin d = klist[i-256]; k = 1'b1; end
                bits = '0;
                if (mode == 0) begin
                    send(d, k, 1'b0);
                    bits[9:0] = oData; nbits = 10;
                end else if (mode == 1) begin
                    send(d, k, 1'b1);
                    bits[9:0] = oData; nbits = 10;
                    sum = -1; run = 0; last = -1;
                end else begin
                    send(8'hBC, 1'b1, 1'b1);
                    bits[19:10] = oData;
                    send(d, k, 1'b0);
                    bits[9:0] = oData; nbits = 20;
                    sum = -1; run = 0; last = -1;
                end
                if (mode != 0) seen[i] = bits[9:0];
                ones = 0; max_run = 0; bad_sum = 1; bad_ones = 5;
                for (int j = 0; j < nbits; j++) begin
                    int b;
                    b = int'(bits[nbits-1-j]);
                    sum += (b != 0) ? 1 : -1;
                    ones += b;
                    if (b == last) run++;
                    else begin run = 1; last = b; end
                    if (run > max_run) max_run = run;
                    if ((j % 10 == 5) || (j % 10 == 9))
                        if (sum != 1 && sum != -1) bad_sum = sum;
                    if (j % 10 == 9) begin
                        if (ones < 4 || ones > 6) bad_ones = ones;
                        ones = 0;
                    end
                end
                total_cnt++;
                if (max_run > 5) $display("FAIL sweep_run m%0d s%0d: run=%0d required<=5 bits=%b", mode, i, max_run, bits);
                else pass_cnt++;
                total_cnt++;
                if (bad_sum != 1) $display("FAIL sweep_rds m%0d s%0d: rds=%0d required=+-1 bits=%b", mode, i, bad_sum, bits);
                else pass_cnt++;
                total_cnt++;
                if (bad_ones != 5) $display("FAIL sweep_disp m%0d s%0d: ones=%0d required=4..6 bits=%b", mode, i, bad_ones, bits);
                else pass_cnt++;
            end
            if (mode != 0) begin
                dups = 0;
                for (int a = 1; a < 268; a++)
                    for (int b2 = 0; b2 < a; b2++)
                        if (seen[a] == seen[b2]) dups++;
                total_cnt++;
                if (dups != 0) $display("FAIL sweep_unique m%0d: duplicates=%0d required=0", mode, dups);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        Reset     = 1'b0;
        iData     = 8'h00;
        TXDATAK   = 1'b0;
        TXCOMP    = 1'b0;
        test_reset();
        test_data();
        test_a7_p7();
        test_k_codes();
        test_compliance();
        test_reset_midstream();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
